// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: reads a little-endian message from SRAM port A and streams padded big-endian words.
// Optional block counter output enabled by defining SHA1_PAD_BLKCNT_EN.
module sha1_msg_padder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       message_addr,
    input  logic [31:0]       message_size,
    output logic              port_A_clk,
    output logic              port_A_we,
    output logic [ADDR_W-1:0] port_A_addr,
    input  logic [31:0]       port_A_data_out,
    output logic [31:0]       word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              block_last,
    output logic              msg_last,
    output logic              busy,
`ifdef SHA1_PAD_BLKCNT_EN
    output logic [26:0]       blk_count,
`endif
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_PAD   = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [31:0]       size_q, size_d;
    logic [30:0]       last_q, last_d;
    logic [30:0]       idx_q, idx_d;
    logic [ADDR_W-1:0] pa_q, pa_d;
    logic [31:0]       word_q, word_d;
    logic              valid_q, valid_d;
    logic              bl_q, bl_d;
    logic              ml_q, ml_d;
    logic              done_q, done_d;
`ifdef SHA1_PAD_BLKCNT_EN
    logic [26:0]       cnt_q, cnt_d;
`endif

    logic [32:0] size_sum;
    logic [26:0] nblk;
    logic [30:0] nxt_idx;
    logic [32:0] nxt_byte;
    logic        more_mem;
    logic [31:0] built;
    logic        unused_addr;

    // Byte b of the stream: message byte, 0x80 marker, zero fill; last two words carry the bit length.
    function automatic logic [31:0] build_word(
        input logic [30:0] idx,
        input logic [30:0] last,
        input logic [31:0] size,
        input logic [31:0] mem,
        input logic        use_mem
    );
        logic [31:0] w;
        logic [32:0] b;
        logic [7:0]  byt;
        w = 32'h0;
        for (int j = 0; j < 4; j++) begin
            b = {idx, 2'b00} + 33'(j);
            if (b < {1'b0, size}) begin
                byt = use_mem ? mem[8*j +: 8] : 8'h00;
            end else if (b == {1'b0, size}) begin
                byt = 8'h80;
            end else begin
                byt = 8'h00;
            end
            w[8*(3-j) +: 8] = byt;
        end
        if (idx == last - 31'd1) begin
            w = {29'h0, size[31:29]};
        end else if (idx == last) begin
            w = {size[28:0], 3'b000};
        end
        return w;
    endfunction

    assign size_sum = {1'b0, message_size} + 33'd8;
    assign nblk     = size_sum[32:6] + 27'd1;
    assign nxt_idx  = idx_q + 31'd1;
    assign nxt_byte = {nxt_idx, 2'b00};
    assign more_mem = nxt_byte < {1'b0, size_q};
    assign built    = build_word(idx_q, last_q, size_q, port_A_data_out,
                                 state_q == S_WAIT);

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        last_d  = last_q;
        idx_d   = idx_q;
        pa_d    = pa_q;
        word_d  = word_q;
        valid_d = valid_q;
        bl_d    = bl_q;
        ml_d    = ml_q;
        done_d  = 1'b0;
`ifdef SHA1_PAD_BLKCNT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    size_d = message_size;
                    last_d = {nblk - 27'd1, 4'hF};
                    idx_d  = 31'd0;
`ifdef SHA1_PAD_BLKCNT_EN
                    cnt_d  = 27'd0;
`endif
                    if (message_size != 32'd0) begin
                        pa_d    = message_addr[ADDR_W-1:0];
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_PAD;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT, S_PAD: begin
                word_d  = built;
                valid_d = 1'b1;
                bl_d    = idx_q[3:0] == 4'hF;
                ml_d    = idx_q == last_q;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    bl_d    = 1'b0;
                    ml_d    = 1'b0;
`ifdef SHA1_PAD_BLKCNT_EN
                    if (bl_q) begin
                        cnt_d = cnt_q + 27'd1;
                    end
`endif
                    if (ml_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = nxt_idx;
                        if (more_mem) begin
                            pa_d    = pa_q + ADDR_W'(4);
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_PAD;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            size_q  <= 32'h0;
            last_q  <= 31'h0;
            idx_q   <= 31'h0;
            pa_q    <= '0;
            word_q  <= 32'h0;
            valid_q <= 1'b0;
            bl_q    <= 1'b0;
            ml_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHA1_PAD_BLKCNT_EN
            cnt_q   <= 27'h0;
`endif
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            pa_q    <= pa_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            bl_q    <= bl_d;
            ml_q    <= ml_d;
            done_q  <= done_d;
`ifdef SHA1_PAD_BLKCNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign port_A_clk  = clk;
    assign port_A_we   = 1'b0;
    assign port_A_addr = pa_q;
    assign word_out    = word_q;
    assign word_valid  = valid_q;
    assign block_last  = bl_q;
    assign msg_last    = ml_q;
    assign done        = done_q;
    assign busy        = state_q != S_IDLE;
`ifdef SHA1_PAD_BLKCNT_EN
    assign blk_count   = cnt_q;
`endif

    // Upper address bits and the word-aligned low bits carry no information here.
    assign unused_addr = ^{message_addr[31:ADDR_W], message_addr[1:0]};

endmodule
